// File: rtl/mux41_scan_sequencer.sv
// Scan sequencer for a MUX41bh: steps the selects, samples Y into a 4-bit frame, and hands it off with a valid/ready handshake.
// Optional change-only delivery is enabled with the macro MUX41_SCAN_CHANGE_DETECT_EN.
`timescale 1ns/1ps
module mux41_scan_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       S0,
  output logic       S1,
  input  logic       Y,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] frame_q, frame_d;
  logic       valid_q, valid_d;
  logic [1:0] s_q, s_d;
  logic [3:0] shadow_cap_s;
  logic       skip_s;
`ifdef MUX41_SCAN_CHANGE_DETECT_EN
  logic       delivered_q, delivered_d;
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
`ifdef MUX41_SCAN_CHANGE_DETECT_EN
    delivered_d = delivered_q;
`endif
    shadow_cap_s        = shadow_q;
    shadow_cap_s[sel_q] = Y;
`ifdef MUX41_SCAN_CHANGE_DETECT_EN
    skip_s = delivered_q && (shadow_cap_s == frame_q);
`else
    skip_s = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SETTLE;
          sel_d   = 2'd0;
          cnt_d   = CNT_RELOAD;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (!en) begin
          // Abort discards the partial shadow; frame keeps its last value.
          state_d  = IDLE;
          sel_d    = 2'd0;
          cnt_d    = 4'd0;
          shadow_d = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          shadow_d = shadow_cap_s;
          cnt_d    = CNT_RELOAD;
          if (sel_q != 2'd3) begin
            sel_d = sel_q + 2'd1;
          end else begin
            sel_d = 2'd0;
            if (skip_s) begin
              state_d = SETTLE;
            end else begin
              state_d = PRESENT;
              frame_d = shadow_cap_s;
`ifdef MUX41_SCAN_CHANGE_DETECT_EN
              delivered_d = 1'b1;
`endif
            end
          end
        end
      end
      PRESENT: begin
        if (frame_ready) begin
          sel_d = 2'd0;
          if (en) begin
            state_d = SETTLE;
            cnt_d   = CNT_RELOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 2'd0;
        cnt_d   = 4'd0;
      end
    endcase

    valid_d = (state_d == PRESENT);
    s_d     = (state_d == SETTLE) ? sel_d : 2'd0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      cnt_q    <= 4'd0;
      shadow_q <= 4'd0;
      frame_q  <= 4'd0;
      valid_q  <= 1'b0;
      s_q      <= 2'd0;
`ifdef MUX41_SCAN_CHANGE_DETECT_EN
      delivered_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
      s_q      <= s_d;
`ifdef MUX41_SCAN_CHANGE_DETECT_EN
      delivered_q <= delivered_d;
`endif
    end
  end

  assign S0          = s_q[0];
  assign S1          = s_q[1];
  assign frame       = frame_q;
  assign frame_valid = valid_q;

endmodule

// File: tb/tb_mux41_scan_sequencer.sv
// Bench for mux41_scan_sequencer: two instances (SETTLE_CYCLES=1 and 0) behind MUX41bh models,
// checked every cycle against a scan-position model plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_mux41_scan_sequencer;

`ifdef MUX41_SCAN_CHANGE_DETECT_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, ready, s0a, s1a, ya, valid_a;
  logic [3:0] in_a, frame_a;
  logic       rst_nb, enb, readyb, s0b, s1b, yb, valid_b;
  logic [3:0] in_b, frame_b;

  assign ya = in_a[{s1a, s0a}];
  assign yb = in_b[{s1b, s0b}];

  mux41_scan_sequencer #(.SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .S0(s0a), .S1(s1a), .Y(ya),
    .frame(frame_a), .frame_valid(valid_a), .frame_ready(ready));

  mux41_scan_sequencer #(.SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_nb), .en(enb), .S0(s0b), .S1(s1b), .Y(yb),
    .frame(frame_b), .frame_valid(valid_b), .frame_ready(readyb));

  // Model: mode 0 idle, 1 scanning (t = cycle position in scan), 2 presenting.
  typedef struct {
    int         mode;
    int         t;
    logic [3:0] shadow;
    logic [3:0] frame;
    bit         delivered;
  } mstate_t;

  mstate_t ma = '{0, 0, 4'd0, 4'd0, 1'b0};
  mstate_t mb = '{0, 0, 4'd0, 4'd0, 1'b0};

  function automatic mstate_t mstep(input mstate_t m, input int n, input logic rn,
                                    input logic e, input logic rdy, input logic [3:0] inp);
    mstate_t r = m;
    int      sel;
    if (!rn) begin
      r = '{0, 0, 4'd0, 4'd0, 1'b0};
    end else if (m.mode == 0) begin
      if (e) begin r.mode = 1; r.t = 0; end
    end else if (m.mode == 1) begin
      if (!e) begin
        r.mode = 0; r.t = 0; r.shadow = 4'd0;
      end else begin
        sel = m.t / (n + 1);
        if (m.t % (n + 1) == n) r.shadow[sel] = inp[sel];
        if (m.t == 4 * (n + 1) - 1) begin
          r.t = 0;
          if (CD && m.delivered && r.shadow == m.frame) r.mode = 1;
          else begin r.mode = 2; r.frame = r.shadow; r.delivered = 1'b1; end
        end else begin
          r.t = m.t + 1;
        end
      end
    end else begin
      if (rdy) begin r.mode = e ? 1 : 0; r.t = 0; end
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_out(input mstate_t m, input int n);
    logic [1:0] s;
    s = (m.mode == 1) ? 2'(m.t / (n + 1)) : 2'd0;
    return {s, (m.mode == 2), m.frame};
  endfunction

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ma <= mstep(ma, 1, rst_n, en, ready, in_a);
    mb <= mstep(mb, 0, rst_nb, enb, readyb, in_b);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_a", {25'd0, s1a, s0a, valid_a, frame_a}, {25'd0, exp_out(ma, 1)});
      check("model_b", {25'd0, s1b, s0b, valid_b, frame_b}, {25'd0, exp_out(mb, 0)});
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int seq [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int pulses, dbl;
    bit prev;
    rst_n = 1'b0; en = 1'b0; ready = 1'b0; in_a = 4'd0;
    rst_nb = 1'b0; enb = 1'b0; readyb = 1'b0; in_b = 4'b0110;
    repeat (2) edge1();
    chk_on = 1'b1;
    check("reset_a", {25'd0, s1a, s0a, valid_a, frame_a}, 32'd0);
    check("reset_b", {25'd0, s1b, s0b, valid_b, frame_b}, 32'd0);

    // SETTLE_CYCLES=0: a one-cycle pulse with 0110 every 5 edges.
    rst_nb = 1'b1; enb = 1'b1; readyb = 1'b1;
    pulses = 0; dbl = 0; prev = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      edge1();
      if (valid_b) begin
        pulses++;
        check("frame_b", {28'd0, frame_b}, 32'h6);
        if (prev) dbl++;
      end
      prev = valid_b;
    end
    check("pulses_b", pulses, 32'd10);
    check("double_b", dbl, 32'd0);

    // Default settle: select sequence and valid on the 9th edge; early ready ignored.
    in_a = 4'b1101; rst_n = 1'b1; en = 1'b1; ready = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      edge1();
      if (n <= 8) begin
        check("sel_seq", {30'd0, s1a, s0a}, seq[n-1]);
        check("valid_early", {31'd0, valid_a}, 32'd0);
      end
      if (n == 7) ready = 1'b0;
    end
    check("valid_9th", {31'd0, valid_a}, 32'd1);
    check("frame_9th", {28'd0, frame_a}, 32'hd);

    // Hold in PRESENT with inputs toggling.
    for (int n = 0; n < 20; n++) begin
      in_a = 4'($urandom);
      edge1();
      check("hold_valid", {31'd0, valid_a}, 32'd1);
      check("hold_frame", {28'd0, frame_a}, 32'hd);
      check("hold_sel", {30'd0, s1a, s0a}, 32'd0);
    end
    ready = 1'b1;
    edge1();
    ready = 1'b0;
    check("release_valid", {31'd0, valid_a}, 32'd0);
    edge1();
    edge1();
    check("rescan_sel1", {30'd0, s1a, s0a}, 32'd1);

    // Abort in the 4th SETTLE cycle.
    rst_n = 1'b0;
    edge1();
    rst_n = 1'b1; en = 1'b1; in_a = 4'b1111;
    repeat (4) edge1();
    check("abort_pre_sel", {30'd0, s1a, s0a}, 32'd1);
    en = 1'b0;
    edge1();
    check("abort_sel", {30'd0, s1a, s0a}, 32'd0);
    for (int n = 0; n < 10; n++) begin
      edge1();
      check("abort_valid", {31'd0, valid_a}, 32'd0);
      check("abort_frame", {28'd0, frame_a}, 32'd0);
    end

    // Reset while presenting.
    en = 1'b1; ready = 1'b0;
    repeat (9) edge1();
    check("pres_valid", {31'd0, valid_a}, 32'd1);
    check("pres_frame", {28'd0, frame_a}, 32'hf);
    rst_n = 1'b0;
    edge1();
    check("reset_pres", {25'd0, s1a, s0a, valid_a, frame_a}, 32'd0);

    // Static inputs, then I3 changes: delivery depends on change detection.
    rst_n = 1'b1; en = 1'b1; ready = 1'b1; in_a = 4'b0011;
    pulses = 0;
    for (int n = 1; n <= 40; n++) begin
      edge1();
      if (valid_a) begin
        pulses++;
        check("frame_static", {28'd0, frame_a}, 32'h3);
      end
    end
    check("pulses_static", pulses, CD ? 32'd1 : 32'd4);
    in_a = 4'b1011;
    pulses = 0;
    for (int n = 41; n <= 80; n++) begin
      edge1();
      if (valid_a) pulses++;
    end
    check("pulses_change", pulses, CD ? 32'd1 : 32'd4);
    check("frame_change", {28'd0, frame_a}, 32'hb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
